// File: rtl/alu_share_sched.sv
// alu_share_sched: round-robin scheduler sharing one registered add / half-width multiply
// datapath between NREQ requesters.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   req_valid/req_ready    per-requester handshake; req_ready is one-hot or zero
//   req_op                 per requester: 0 = add, 1 = multiply
//   req_a/req_b            packed operands, requester i at [i*W +: W]
//   resp_valid/resp_ready  result handshake with backpressure
//   resp_id/resp_data      requester index and result
//   stat_ops/stat_stall    accepted-request and stall-cycle counters, present only when
//                          ALU_SCHED_STATS_EN is defined
//
// Pipeline: S1 operand register -> S2 result register. Both stages advance together when
// S2 is empty or being drained (adv); otherwise everything freezes and no grant is issued.
module alu_share_sched #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned W    = 16,
  parameter int unsigned IDW  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ-1:0]   req_op,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [IDW-1:0]    resp_id,
  output logic [W-1:0]      resp_data
`ifdef ALU_SCHED_STATS_EN
  ,
  output logic [31:0]       stat_ops,
  output logic [31:0]       stat_stall
`endif
);

  logic           s1_valid_q, s1_valid_d;
  logic [IDW-1:0] s1_id_q, s1_id_d;
  logic           s1_op_q, s1_op_d;
  logic [W-1:0]   s1_a_q, s1_a_d;
  logic [W-1:0]   s1_b_q, s1_b_d;
  logic           resp_valid_q, resp_valid_d;
  logic [IDW-1:0] resp_id_q, resp_id_d;
  logic [W-1:0]   resp_data_q, resp_data_d;
  logic [IDW-1:0] ptr_q, ptr_d;

  logic           adv;
  logic           xfer;
  logic           gnt_found;
  logic [IDW-1:0] gnt_id;
  logic           sel_op;
  logic [W-1:0]   sel_a, sel_b;
  logic [W-1:0]   alu_res;

  assign adv  = !resp_valid_q || resp_ready;
  assign xfer = adv && gnt_found;

  // Round-robin search starting just after the last transferred requester.
  always_comb begin
    gnt_found = 1'b0;
    gnt_id    = '0;
    sel_op    = 1'b0;
    sel_a     = '0;
    sel_b     = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      int unsigned idx;
      idx = (32'(ptr_q) + k) % NREQ;
      if (!gnt_found && req_valid[idx]) begin
        gnt_found = 1'b1;
        gnt_id    = IDW'(idx);
        sel_op    = req_op[idx];
        sel_a     = req_a[idx*W +: W];
        sel_b     = req_b[idx*W +: W];
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (xfer) begin
      req_ready[gnt_id] = 1'b1;
    end
  end

  // Multiply uses only the low half of each operand; the full product fits in W bits.
  always_comb begin
    if (s1_op_q) begin
      alu_res = W'(s1_a_q[W/2-1:0]) * W'(s1_b_q[W/2-1:0]);
    end else begin
      alu_res = s1_a_q + s1_b_q;
    end
  end

  always_comb begin
    s1_valid_d   = s1_valid_q;
    s1_id_d      = s1_id_q;
    s1_op_d      = s1_op_q;
    s1_a_d       = s1_a_q;
    s1_b_d       = s1_b_q;
    resp_valid_d = resp_valid_q;
    resp_id_d    = resp_id_q;
    resp_data_d  = resp_data_q;
    ptr_d        = ptr_q;
    if (adv) begin
      resp_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        resp_id_d   = s1_id_q;
        resp_data_d = alu_res;
      end
      s1_valid_d = xfer;
      if (xfer) begin
        s1_id_d = gnt_id;
        s1_op_d = sel_op;
        s1_a_d  = sel_a;
        s1_b_d  = sel_b;
        ptr_d   = gnt_id;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q   <= 1'b0;
      s1_id_q      <= '0;
      s1_op_q      <= 1'b0;
      s1_a_q       <= '0;
      s1_b_q       <= '0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= '0;
      resp_data_q  <= '0;
      ptr_q        <= IDW'(NREQ - 1);  // requester 0 searched first after reset
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_id_q      <= s1_id_d;
      s1_op_q      <= s1_op_d;
      s1_a_q       <= s1_a_d;
      s1_b_q       <= s1_b_d;
      resp_valid_q <= resp_valid_d;
      resp_id_q    <= resp_id_d;
      resp_data_q  <= resp_data_d;
      ptr_q        <= ptr_d;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_id    = resp_id_q;
  assign resp_data  = resp_data_q;

`ifdef ALU_SCHED_STATS_EN
  logic [31:0] stat_ops_q, stat_ops_d;
  logic [31:0] stat_stall_q, stat_stall_d;

  always_comb begin
    stat_ops_d   = stat_ops_q + 32'(xfer);
    stat_stall_d = stat_stall_q + 32'(resp_valid_q && !resp_ready);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_ops_q   <= '0;
      stat_stall_q <= '0;
    end else begin
      stat_ops_q   <= stat_ops_d;
      stat_stall_q <= stat_stall_d;
    end
  end

  assign stat_ops   = stat_ops_q;
  assign stat_stall = stat_stall_q;
`endif

endmodule

// File: tb/tb_alu_share_sched.sv
// Self-checking bench for alu_share_sched. Requesters are fed from a pending-vector queue;
// every accept pushes the hand-computed result onto a scoreboard that a separate monitor pops
// whenever a result handshake occurs. Build with ALU_SCHED_STATS_EN to exercise the counters.
module tb_alu_share_sched;

  localparam int NREQ = 4;
  localparam int W    = 16;
  localparam int IDW  = 2;

  logic              clk;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ-1:0]   req_op;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic              resp_valid;
  logic              resp_ready;
  logic [IDW-1:0]    resp_id;
  logic [W-1:0]      resp_data;
`ifdef ALU_SCHED_STATS_EN
  logic [31:0]       stat_ops;
  logic [31:0]       stat_stall;
`endif

  alu_share_sched #(
    .NREQ (NREQ),
    .W    (W),
    .IDW  (IDW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_data  (resp_data)
`ifdef ALU_SCHED_STATS_EN
    ,
    .stat_ops   (stat_ops),
    .stat_stall (stat_stall)
`endif
  );

  typedef struct {
    int          id;
    logic        op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] exp;
  } vec_t;

  typedef struct {
    int          id;
    logic [15:0] data;
  } exp_t;

  vec_t            pend[$];
  exp_t            expq[$];
  int              grant_log[$];
  logic [NREQ-1:0] acc_mask;
  int              n_cmp;
  int              n_err;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int find_first(input int id);
    for (int i = 0; i < pend.size(); i++) begin
      if (pend[i].id == id) return i;
    end
    return -1;
  endfunction

  task automatic push_vec(input int id, input logic op, input logic [15:0] a,
                          input logic [15:0] b, input logic [15:0] exp);
    vec_t v;
    v.id  = id;
    v.op  = op;
    v.a   = a;
    v.b   = b;
    v.exp = exp;
    pend.push_back(v);
  endtask

  // Each requester presents its oldest pending vector.
  task automatic refresh();
    req_valid = '0;
    req_op    = '0;
    req_a     = '0;
    req_b     = '0;
    for (int i = 0; i < NREQ; i++) begin
      int j;
      j = find_first(i);
      if (j >= 0) begin
        req_valid[i]       = 1'b1;
        req_op[i]          = pend[j].op;
        req_a[i*W +: W]    = pend[j].a;
        req_b[i*W +: W]    = pend[j].b;
      end
    end
  endtask

  // Retire vectors accepted at the edge just passed, then present the next ones.
  always begin
    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++) begin
      if (acc_mask[i]) begin
        int j;
        j = find_first(i);
        if (j >= 0) pend.delete(j);
      end
    end
    acc_mask = '0;
    refresh();
  end

  // Monitor: record accepts as scoreboard entries, compare results on handshake.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < NREQ; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          int   j;
          exp_t e;
          acc_mask[i] = 1'b1;
          grant_log.push_back(i);
          j = find_first(i);
          e.id   = i;
          e.data = (j >= 0) ? pend[j].exp : 16'hxxxx;
          expq.push_back(e);
        end
      end
      if (resp_valid && resp_ready) begin
        if (expq.size() == 0) begin
          chk("unexpected_resp", 32'(resp_id), 32'hffff_ffff);
        end else begin
          exp_t e;
          e = expq.pop_front();
          chk("resp_id", 32'(resp_id), 32'(e.id));
          chk("resp_data", 32'(resp_data), 32'(e.data));
        end
      end
    end
  end

  task automatic wait_drain(input string nm);
    int t;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while ((pend.size() != 0 || expq.size() != 0 || resp_valid) && t < 200);
    chk({nm, "_drain_timeout"}, 32'(t >= 200), 32'd0);
  endtask

  task automatic wait_resp_valid(input string nm);
    int t;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!resp_valid && t < 20);
    chk({nm, "_resp_timeout"}, 32'(resp_valid), 32'd1);
  endtask

  int          t;
  int          lat;
  logic [1:0]  hold_id;
  logic [15:0] hold_data;

  initial begin
    n_cmp      = 0;
    n_err      = 0;
    acc_mask   = '0;
    rst_n      = 1'b1;
    resp_ready = 1'b1;
    refresh();

    // Reset state.
    #3 rst_n = 1'b0;
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_id", 32'(resp_id), 32'd0);
    chk("rst_resp_data", 32'(resp_data), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Add with carry discarded, and two-cycle latency.
    @(posedge clk);
    #1;
    push_vec(1, 1'b0, 16'hFFFF, 16'h0002, 16'h0001);
    refresh();
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!(req_valid[1] && req_ready[1]) && t < 10);
    chk("add_accept", 32'(req_ready), 32'b0010);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!resp_valid && lat < 10);
    chk("add_latency", 32'(lat), 32'd2);
    wait_drain("add");

    // Multiply uses the low bytes only.
    @(posedge clk);
    #1;
    push_vec(3, 1'b1, 16'h12FF, 16'h34FF, 16'hFE01);
    refresh();
    wait_drain("mul");

    // Fairness: all four valid continuously, ptr last at 3.
    @(posedge clk);
    #1;
    grant_log.delete();
    push_vec(0, 1'b0, 16'h1000, 16'h0234, 16'h1234);
    push_vec(1, 1'b1, 16'h0003, 16'h0005, 16'h000F);
    push_vec(2, 1'b0, 16'h8000, 16'h8000, 16'h0000);
    push_vec(3, 1'b1, 16'hAB10, 16'hCD10, 16'h0100);
    push_vec(0, 1'b0, 16'h0001, 16'h0001, 16'h0002);
    push_vec(1, 1'b0, 16'h7FFF, 16'h0001, 16'h8000);
    push_vec(2, 1'b1, 16'h0080, 16'h0002, 16'h0100);
    push_vec(3, 1'b1, 16'h00FF, 16'h0001, 16'h00FF);
    refresh();
    wait_drain("fair");
    chk("fair_grant_count", 32'(grant_log.size()), 32'd8);
    for (int i = 0; i < 8 && i < grant_log.size(); i++) begin
      chk($sformatf("fair_grant_%0d", i), 32'(grant_log[i]), 32'(i % 4));
    end

    // Backpressure with a withdrawn request; ptr stays at 3 so requester 1 beats 3.
    @(posedge clk);
    #1;
    grant_log.delete();
    resp_ready = 1'b0;
    push_vec(3, 1'b0, 16'h0100, 16'h0011, 16'h0111);
    refresh();
    wait_resp_valid("bp");
    hold_id   = resp_id;
    hold_data = resp_data;
    chk("bp_hold_id", 32'(hold_id), 32'd3);
    chk("bp_hold_data", 32'(hold_data), 32'h0111);
    @(posedge clk);
    #1;
    push_vec(2, 1'b0, 16'h2222, 16'h1111, 16'h3333);
    refresh();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk($sformatf("bp_req_ready_%0d", c), 32'(req_ready), 32'd0);
      chk($sformatf("bp_id_stable_%0d", c), 32'(resp_id), 32'(hold_id));
      chk($sformatf("bp_data_stable_%0d", c), 32'(resp_data), 32'(hold_data));
      @(posedge clk);
      #1;
      if (c == 1) pend.delete(find_first(2));
      if (c == 3) begin
        push_vec(1, 1'b1, 16'h0010, 16'h0010, 16'h0100);
        push_vec(3, 1'b0, 16'h0005, 16'h0006, 16'h000B);
      end
      refresh();
    end
    resp_ready = 1'b1;
    wait_drain("bp");
    chk("bp_grant_count", 32'(grant_log.size()), 32'd3);
    if (grant_log.size() == 3) begin
      chk("bp_grant_0", 32'(grant_log[0]), 32'd3);
      chk("bp_grant_1", 32'(grant_log[1]), 32'd1);
      chk("bp_grant_2", 32'(grant_log[2]), 32'd3);
    end

    // Reset mid-stream with S1 and S2 occupied.
    @(posedge clk);
    #1;
    push_vec(0, 1'b0, 16'h0011, 16'h0022, 16'h0033);
    push_vec(1, 1'b0, 16'h0044, 16'h0055, 16'h0099);
    push_vec(2, 1'b0, 16'h0066, 16'h0077, 16'h00DD);
    push_vec(3, 1'b0, 16'h0088, 16'h0099, 16'h0121);
    refresh();
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b0;
    pend.delete();
    expq.delete();
    acc_mask = '0;
    refresh();
    #1;
    chk("mid_rst_req_ready", 32'(req_ready), 32'd0);
    chk("mid_rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("mid_rst_resp_id", 32'(resp_id), 32'd0);
    chk("mid_rst_resp_data", 32'(resp_data), 32'd0);
    repeat (2) @(negedge clk);
    chk("mid_rst_hold_valid", 32'(resp_valid), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    grant_log.delete();
    push_vec(2, 1'b0, 16'h0002, 16'h0003, 16'h0005);
    refresh();
    wait_drain("post_rst");
    chk("post_rst_grant_count", 32'(grant_log.size()), 32'd1);
    if (grant_log.size() == 1) chk("post_rst_grant", 32'(grant_log[0]), 32'd2);

`ifdef ALU_SCHED_STATS_EN
    // Ten accepts and exactly five stall cycles after a fresh reset.
    @(posedge clk);
    #1 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    chk("stat_ops_rst", stat_ops, 32'd0);
    chk("stat_stall_rst", stat_stall, 32'd0);
    for (int k = 0; k < 10; k++) begin
      push_vec(k % 4, 1'b0, 16'(k), 16'h0100, 16'h0100 + 16'(k));
    end
    refresh();
    wait_resp_valid("stats");
    @(posedge clk);
    #1 resp_ready = 1'b0;
    repeat (5) @(posedge clk);
    #1 resp_ready = 1'b1;
    wait_drain("stats");
    chk("stat_ops", stat_ops, 32'd10);
    chk("stat_stall", stat_stall, 32'd5);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
